seq_pattern_detector: RTL

Parametrised serial pattern detector, successor to the fixed four-ones detector. It compares a one-bit input stream against a runtime-loadable PAT_W-bit pattern and raises a one-cycle match pulse. The stream carries a valid qualifier, and the block supports overlapping and non-overlapping match modes plus an optional saturating match counter. It sits between a serial receive front end and the frame/control logic that consumes match events.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_match_counter.sv | 29 ++
 rtl/seq_pattern_detector.sv | 106 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
// The match counter is present only when SEQDET_MATCH_COUNT_EN is defined.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_NOOVL = 1'b0;
    localparam logic MODE_OVL   = 1'b1;

    localparam int MAX_PAT_W = 64;

    // Low w bits set; the caller narrows the result to its own width.
    function automatic logic [MAX_PAT_W-1:0] ones_pat(input int w);
        return {MAX_PAT_W{1'b1}} >> (MAX_PAT_W - w);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter; a clear that coincides with an increment yields 1.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = inc_i ? CNT_W'(1) : '0;
        else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial detector matching a loadable PAT_W-bit pattern, overlapping or not.
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(ones_pat(PAT_W)),
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, hist_sh;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic             match_q, match_d, armed_q, armed_d;
    logic             accept, full_now, drop_hist;

    // A load in the same cycle discards the input bit.
    assign accept    = in_valid && !pat_load;
    assign hist_sh   = {hist_q[PAT_W-2:0], in};
    assign full_now  = (state_q == ST_RUN) || (fill_q == FILL_W'(PAT_W - 1));
    assign match_d   = accept && full_now && (hist_sh == pat_q);
    assign drop_hist = match_d && (overlap == MODE_NOOVL);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (pat_load)
            state_d = ST_FILL;
        else if (accept) begin
            if (drop_hist)     state_d = ST_FILL;
            else if (full_now) state_d = ST_RUN;
        end
    end

    always_comb begin
        armed_d = (state_d == ST_RUN);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (pat_load) begin
            pat_d  = pat_value;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_sh;
            if (drop_hist)
                fill_d = '0;
            else if (state_q == ST_FILL)
                fill_d = fill_q + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_RESET;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            match_q <= match_d;
            armed_q <= armed_d;
        end
    end

    assign match = match_q;
    assign armed = armed_q;

`ifdef SEQDET_MATCH_COUNT_EN
    seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (match_d),
        .clr_i  (cnt_clr),
        .cnt_o  (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule
